branch_resolver: RTL and testbench



---
 rtl/branch_pkg.sv | 14 +
 rtl/branch_resolver_if.sv | 44 ++++
 rtl/outcome_fifo.sv | 56 +++++
 rtl/branch_resolver.sv | 116 +++++++++++
 tb/tb_branch_resolver.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_pkg.sv
// Shared types and defaults for the branch resolver.
// FSM state encoding plus default queue depth and counter width.
package branch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam int DEPTH_DEF = 4;
    localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/branch_resolver_if.sv
// Fetch / predictor / execute bundle for the branch resolver.
// slave is the resolver's view, master is the environment's view.
interface branch_resolver_if
    import branch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    localparam int OW = $clog2(DEPTH + 1);

    logic             fetch_valid;
    logic             fetch_ready;
    logic             request;
    logic             prediction;
    logic             pred_valid;
    logic             pred_taken;
    logic             resolve_valid;
    logic             resolve_taken;
    logic             result;
    logic             taken;
    logic             mispredict;
    logic [CNT_W-1:0] mispredict_count;
    logic [OW-1:0]    outstanding;
    logic             error;

    modport slave (
        input  fetch_valid, prediction,
        input  resolve_valid, resolve_taken,
        output fetch_ready, request,
        output pred_valid, pred_taken,
        output result, taken, mispredict,
        output mispredict_count, outstanding, error
    );

    modport master (
        output fetch_valid, prediction,
        output resolve_valid, resolve_taken,
        input  fetch_ready, request,
        input  pred_valid, pred_taken,
        input  result, taken, mispredict,
        input  mispredict_count, outstanding, error
    );

endinterface

// File: rtl/outcome_fifo.sv
// 1-bit wide, DEPTH-entry FIFO holding predictions in program order.
// Flush empties the queue and overrides any push or pop that cycle.
module outcome_fifo
    import branch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_din,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic                       o_dout,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] r_mem;
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_cnt;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_cnt == CW'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;
    assign o_dout  = r_mem[r_rd];
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);

    // Storage write; contents are don't-care until pushed
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wr] <= i_din;
        end
    end

    // Pointers and occupancy; pointers wrap naturally
    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: rtl/branch_resolver.sv
// Drives predictor requests, queues predictions, resolves against execute.
// BRANCH_RESOLVER_STATS_EN enables the saturating mispredict counter.
module branch_resolver
    import branch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    branch_resolver_if.slave bus
);
    localparam int OW = $clog2(DEPTH + 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_request;
    logic          r_pred_valid;
    logic          r_pred_taken;
    logic          r_result;
    logic          r_taken;
    logic          r_mispredict;
    logic          r_error;
    logic          w_full;
    logic          w_empty;
    logic          w_head;
    logic [OW-1:0] w_count;
    logic          w_accept;
    logic          w_hit;
    logic          w_mis;
    logic          w_push;

    assign w_accept = (r_state == IDLE) && !w_full && bus.fetch_valid;
    assign w_hit    = bus.resolve_valid && !w_empty;
    assign w_mis    = w_hit && (w_head != bus.resolve_taken);
    assign w_push   = (r_state == CAPTURE) && !w_mis;

    outcome_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   (bus.prediction),
        .i_pop   (w_hit),
        .i_flush (w_mis),
        .o_dout  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Request sequencing; a mispredict aborts an in-flight request
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_state_nxt = REQ;
            REQ:     w_state_nxt = w_mis ? IDLE : CAPTURE;
            CAPTURE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Registered pulses toward predictor, fetch and execute
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_request    <= 1'b0;
            r_pred_valid <= 1'b0;
            r_pred_taken <= 1'b0;
            r_result     <= 1'b0;
            r_taken      <= 1'b0;
            r_mispredict <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_request    <= w_accept;
            r_pred_valid <= w_push;
            r_pred_taken <= w_push & bus.prediction;
            r_result     <= w_hit;
            r_taken      <= w_hit & bus.resolve_taken;
            r_mispredict <= w_mis;
            if (bus.resolve_valid && w_empty) r_error <= 1'b1;
        end
    end

`ifdef BRANCH_RESOLVER_STATS_EN
    logic [CNT_W-1:0] r_mis_cnt;

    // Saturating count of mispredicts, no wrap
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mis_cnt <= '0;
        end else if (w_mis && (r_mis_cnt != '1)) begin
            r_mis_cnt <= r_mis_cnt + CNT_W'(1);
        end
    end

    assign bus.mispredict_count = r_mis_cnt;
`else
    assign bus.mispredict_count = '0;
`endif

    assign bus.fetch_ready = (r_state == IDLE) && !w_full;
    assign bus.request     = r_request;
    assign bus.pred_valid  = r_pred_valid;
    assign bus.pred_taken  = r_pred_taken;
    assign bus.result      = r_result;
    assign bus.taken       = r_taken;
    assign bus.mispredict  = r_mispredict;
    assign bus.outstanding = w_count;
    assign bus.error       = r_error;

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver with a behavioural 2-bit predictor.
// Expected predictions and queue contents are tracked in bench queues.
module tb_branch_resolver;

    localparam int DEPTH = 4;
    localparam int CNT_W = 2;
    localparam int OW    = $clog2(DEPTH + 1);
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pinit = 1'b0;
    logic [1:0] pcnt;

    int checks = 0;
    int failures = 0;
    int mcount = 0;
    bit exp_pred[$];
    bit mq[$];

    always #5 clk = ~clk;

    branch_resolver_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bif ();

    branch_resolver #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    // Behavioural 2-bit saturating predictor (no reset)
    always @(posedge clk) begin
        if (pinit) begin
            pcnt <= 2'b11;
            bif.prediction <= 1'b0;
        end else begin
            if (bif.result) begin
                if (bif.taken) pcnt <= (pcnt == 2'b11) ? 2'b11 : pcnt + 2'b01;
                else           pcnt <= (pcnt == 2'b00) ? 2'b00 : pcnt - 2'b01;
            end
            if (bif.request) bif.prediction <= pcnt[1];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CNT_W-1:0] exp_cnt();
`ifdef BRANCH_RESOLVER_STATS_EN
        return CNT_W'(mcount);
`else
        return '0;
`endif
    endfunction

    task automatic test_reset();
        bif.fetch_valid = 1'b0;
        bif.resolve_valid = 1'b0;
        bif.resolve_taken = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        mq.delete();
        exp_pred.delete();
        mcount = 0;
        checks++;
        if (bif.request !== 1'b0 || bif.pred_valid !== 1'b0 || bif.pred_taken !== 1'b0) begin
            failures++;
            $display("FAIL reset_fetch_side req=%b pv=%b pt=%b exp 0 0 0",
                     bif.request, bif.pred_valid, bif.pred_taken);
        end
        checks++;
        if (bif.result !== 1'b0 || bif.taken !== 1'b0 || bif.mispredict !== 1'b0) begin
            failures++;
            $display("FAIL reset_resolve_side res=%b tk=%b mis=%b exp 0 0 0",
                     bif.result, bif.taken, bif.mispredict);
        end
        checks++;
        if (bif.mispredict_count !== '0 || bif.outstanding !== '0 || bif.error !== 1'b0) begin
            failures++;
            $display("FAIL reset_state cnt=%0d out=%0d err=%b exp 0 0 0",
                     bif.mispredict_count, bif.outstanding, bif.error);
        end
        checks++;
        if (bif.fetch_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_fetch_ready got=%b exp=1", bif.fetch_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic start_fetch();
        int n;
        n = 0;
        bif.fetch_valid = 1'b1;
        while (bif.fetch_ready !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        if (bif.fetch_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL fetch_ready_timeout got=%b exp=1", bif.fetch_ready);
            bif.fetch_valid = 1'b0;
            return;
        end
        tick();
        bif.fetch_valid = 1'b0;
        exp_pred.push_back(pcnt[1]);
        checks++;
        if (bif.request !== 1'b1) begin
            failures++;
            $display("FAIL request_pulse got=%b exp=1", bif.request);
        end
    endtask

    task automatic finish_fetch();
        int n;
        bit e;
        n = 0;
        do begin
            tick();
            n++;
        end while (bif.pred_valid !== 1'b1 && n < 4);
        checks++;
        if (bif.pred_valid !== 1'b1 || n != 2) begin
            failures++;
            $display("FAIL pred_latency pv=%b cycles=%0d exp pv=1 cycles=2",
                     bif.pred_valid, n);
        end
        if (bif.pred_valid === 1'b1 && exp_pred.size() > 0) begin
            e = exp_pred.pop_front();
            mq.push_back(e);
            checks++;
            if (bif.pred_taken !== e) begin
                failures++;
                $display("FAIL pred_taken got=%b exp=%b", bif.pred_taken, e);
            end
            checks++;
            if (bif.outstanding !== OW'(mq.size())) begin
                failures++;
                $display("FAIL push_outstanding got=%0d exp=%0d",
                         bif.outstanding, mq.size());
            end
        end
        tick();
        checks++;
        if (bif.pred_valid !== 1'b0) begin
            failures++;
            $display("FAIL pred_valid_width got=%b exp=0", bif.pred_valid);
        end
    endtask

    task automatic resolve(input bit t);
        bit h;
        bit em;
        bit emp;
        emp = (mq.size() == 0);
        bif.resolve_valid = 1'b1;
        bif.resolve_taken = t;
        tick();
        bif.resolve_valid = 1'b0;
        bif.resolve_taken = 1'b0;
        if (emp) begin
            checks++;
            if (bif.result !== 1'b0 || bif.mispredict !== 1'b0 || bif.error !== 1'b1) begin
                failures++;
                $display("FAIL empty_resolve res=%b mis=%b err=%b exp 0 0 1",
                         bif.result, bif.mispredict, bif.error);
            end
        end else begin
            h = mq.pop_front();
            em = (h != t);
            if (em) begin
                mq.delete();
                if (mcount < CMAX) mcount++;
            end
            checks++;
            if (bif.result !== 1'b1 || bif.taken !== t || bif.mispredict !== em) begin
                failures++;
                $display("FAIL resolve_pulse res=%b tk=%b mis=%b exp 1 %b %b",
                         bif.result, bif.taken, bif.mispredict, t, em);
            end
            checks++;
            if (bif.outstanding !== OW'(mq.size())) begin
                failures++;
                $display("FAIL pop_outstanding got=%0d exp=%0d",
                         bif.outstanding, mq.size());
            end
        end
        checks++;
        if (bif.mispredict_count !== exp_cnt()) begin
            failures++;
            $display("FAIL mispredict_count got=%0d exp=%0d",
                     bif.mispredict_count, exp_cnt());
        end
        tick();
        checks++;
        if (bif.result !== 1'b0 || bif.mispredict !== 1'b0) begin
            failures++;
            $display("FAIL resolve_width res=%b mis=%b exp 0 0",
                     bif.result, bif.mispredict);
        end
    endtask

    task automatic test_first();
        start_fetch();
        finish_fetch();
        resolve(1'b0);
    endtask

    task automatic test_fill_and_overlap();
        for (int i = 0; i < DEPTH; i++) begin
            start_fetch();
            finish_fetch();
        end
        checks++;
        if (bif.fetch_ready !== 1'b0 || bif.outstanding !== OW'(DEPTH)) begin
            failures++;
            $display("FAIL full_ready rdy=%b out=%0d exp 0 %0d",
                     bif.fetch_ready, bif.outstanding, DEPTH);
        end
        bif.fetch_valid = 1'b1;
        bif.resolve_valid = 1'b1;
        bif.resolve_taken = mq[0];
        tick();
        bif.resolve_valid = 1'b0;
        void'(mq.pop_front());
        checks++;
        if (bif.result !== 1'b1 || bif.mispredict !== 1'b0 || bif.request !== 1'b0) begin
            failures++;
            $display("FAIL overlap_pop res=%b mis=%b req=%b exp 1 0 0",
                     bif.result, bif.mispredict, bif.request);
        end
        checks++;
        if (bif.outstanding !== OW'(DEPTH - 1) || bif.fetch_ready !== 1'b1) begin
            failures++;
            $display("FAIL overlap_ready out=%0d rdy=%b exp %0d 1",
                     bif.outstanding, bif.fetch_ready, DEPTH - 1);
        end
        tick();
        bif.fetch_valid = 1'b0;
        exp_pred.push_back(pcnt[1]);
        checks++;
        if (bif.request !== 1'b1) begin
            failures++;
            $display("FAIL overlap_accept req=%b exp=1", bif.request);
        end
        finish_fetch();
        for (int i = 0; i < DEPTH; i++) resolve(mq[0]);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            start_fetch();
            finish_fetch();
        end
        start_fetch();
        resolve(~mq[0]);
        void'(exp_pred.pop_front());
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bif.pred_valid !== 1'b0 || bif.outstanding !== '0) begin
                failures++;
                $display("FAIL flush_abort pv=%b out=%0d exp 0 0",
                         bif.pred_valid, bif.outstanding);
            end
            tick();
        end
        checks++;
        if (bif.fetch_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_ready got=%b exp=1", bif.fetch_ready);
        end
    endtask

    task automatic test_empty_resolve();
        resolve(1'b1);
        tick();
        checks++;
        if (bif.error !== 1'b1) begin
            failures++;
            $display("FAIL error_sticky got=%b exp=1", bif.error);
        end
    endtask

    task automatic test_saturate();
        test_reset();
        for (int i = 0; i < 5; i++) begin
            start_fetch();
            finish_fetch();
            if (mq.size() > 0) resolve(~mq[0]);
        end
    endtask

    initial begin
        pinit = 1'b1;
        test_reset();
        pinit = 1'b0;
        test_first();
        test_fill_and_overlap();
        test_flush();
        test_empty_resolve();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
